mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 4, is the fixed memory access latency in cycles; legal range 1..15.
REQ-002 Parameter ADDR_W, default 16, is the address width; DATA_W, default 16, is the data width.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 if_req  input  1  instruction-fetch read request, held high until if_valid is seen.
REQ-006 if_addr  input  ADDR_W  fetch address.
REQ-007 if_valid  output  1  one-cycle pulse; if_data holds the fetched word.
REQ-008 if_data  output  DATA_W  registered fetch data.
REQ-009 d_req  input  1  data-access request, held high until d_valid is seen.
REQ-010 d_wr  input  1  1 = store, 0 = load.
REQ-011 d_addr  input  ADDR_W  data address.
REQ-012 d_wdata  input  DATA_W  store data.
REQ-013 d_valid  output  1  one-cycle pulse on load-data-ready or store-complete.
REQ-014 d_rdata  output  DATA_W  registered load data.
REQ-015 mem_en  output  1  memory enable, held for the whole access.
REQ-016 mem_wr  output  1  memory write strobe, held for the whole store access.
REQ-017 mem_addr  output  ADDR_W  memory address, stable for the whole access.
REQ-018 mem_wdata  output  DATA_W  memory write data, stable for the whole access.
REQ-019 mem_rdata  input  DATA_W  memory read data, valid in the last enable cycle.
REQ-020 stall  output  1  pipeline stall to the CPU core.

Function
REQ-021 States: IDLE, BUSY, RESP.
REQ-022 IDLE, no request: remain in IDLE; mem_en = 0.
REQ-023 IDLE, exactly one request: grant it, capture addr/wr/wdata into registers, go to BUSY, load counter with MEM_LAT-1.
REQ-024 IDLE, both requests: grant the requester not granted last (last_grant register); the granted requester's captures apply as in REQ-023.
REQ-025 BUSY: mem_en = 1; mem_wr = captured wr (always 0 for fetch); mem_addr/mem_wdata from captured registers; decrement counter each cycle.
REQ-026 BUSY with counter = 0: register mem_rdata into if_data or d_rdata (loads only), then go to RESP.
REQ-027 RESP: pulse exactly one of if_valid / d_valid for one cycle; requests ignored; go to IDLE.
REQ-028 Latency: request sampled in IDLE at edge T -> mem_en high cycles T+1..T+MEM_LAT -> valid high cycle T+MEM_LAT+1; back-to-back access period MEM_LAT+2.
REQ-029 d_rdata is unchanged by stores; if_data/d_rdata hold their value between accesses.
REQ-030 Request deasserted during BUSY: access completes and valid still pulses.
REQ-031 Address/data changes on inputs during BUSY have no effect on mem_* outputs.
REQ-032 stall = (if_req & ~if_valid) | (d_req & ~d_valid), combinational.
REQ-033 last_grant updates only on grant in IDLE.

Reset
REQ-034 rst high aborts any access immediately, state -> IDLE.
REQ-035 All outputs are 0 while rst is high: mem_en, mem_wr, mem_addr, mem_wdata, if_valid, d_valid, if_data, d_rdata; stall follows REQ-032.
REQ-036 Reset sets last_grant = fetch, so data wins the first simultaneous request.
REQ-037 Reset during BUSY produces no valid pulse after release.

Structure
REQ-038 Shared package wisc_mem_pkg holds the state encoding (IDLE/BUSY/RESP), the MEM_LAT default, ADDR_W/DATA_W, and grant ids (GNT_IF, GNT_D).
REQ-039 Implementation is a single module; no sub-module is required.

Verification
REQ-040 Fetch only: MEM_LAT=4, if_req, if_addr=0x0010, mem_rdata=0xA5A5 in the last enable cycle -> mem_en high 4 cycles with mem_addr=0x0010, if_valid at T+5, if_data=0xA5A5.
REQ-041 Store: d_req, d_wr=1, d_addr=0x0100, d_wdata=0x1234 -> mem_wr=mem_en=1 for 4 cycles with stable addr/data, d_valid at T+5, d_rdata unchanged.
REQ-042 Simultaneous requests after reset -> data served first, fetch served next with mem_en rising at T+7; repeated contention alternates grants.
REQ-043 Reset at BUSY cycle 2 -> mem_en drops asynchronously, no valid pulse, next request timed per REQ-028.
REQ-044 if_addr changed from 0x0010 to 0x0020 and if_req dropped mid-BUSY -> mem_addr stays 0x0010, if_valid still pulses; stall tracks REQ-032 every cycle.
REQ-045 MEM_LAT=1 -> mem_en high 1 cycle, valid at T+2.

Source files
------------

// File: rtl/wisc_mem_pkg.sv
// Shared definitions for the memory arbiter: FSM encoding, grant ids and
// default sizing.
package wisc_mem_pkg;

    localparam int MEM_LAT_DEF = 4;
    localparam int ADDR_W_DEF  = 16;
    localparam int DATA_W_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_D  = 1'b1
    } gnt_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction fetch and data access share one
// fixed-latency memory. Round-robin on contention, one access in flight.
module mem_arbiter
    import wisc_mem_pkg::*;
#(
    parameter int MEM_LAT = MEM_LAT_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_data,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall
);

    // Counter counts down the remaining enable cycles; 4 bits covers 1..15.
    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    state_t            state, state_nxt;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              wr_q;
    gnt_t              gnt_q;
    gnt_t              last_grant;
    gnt_t              gnt_sel;
    logic              any_req;

    // Pick a winner: alternate against last_grant when both ask.
    always_comb begin
        any_req = if_req | d_req;
        gnt_sel = GNT_IF;
        if (if_req && d_req)
            gnt_sel = (last_grant == GNT_IF) ? GNT_D : GNT_IF;
        else if (d_req)
            gnt_sel = GNT_D;
    end

    // State register; reset aborts any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = BUSY;
            BUSY:    if (cnt == 4'd0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Capture the granted request, count the access, land read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wr_q       <= 1'b0;
            gnt_q      <= GNT_IF;
            last_grant <= GNT_IF;
            if_data    <= '0;
            d_rdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt_q      <= gnt_sel;
                        last_grant <= gnt_sel;
                        cnt        <= LAT_M1;
                        if (gnt_sel == GNT_D) begin
                            addr_q  <= d_addr;
                            wr_q    <= d_wr;
                            wdata_q <= d_wdata;
                        end else begin
                            addr_q  <= if_addr;
                            wr_q    <= 1'b0;
                            wdata_q <= '0;
                        end
                    end
                end
                BUSY: begin
                    if (cnt == 4'd0) begin
                        // Stores leave d_rdata untouched.
                        if (gnt_q == GNT_IF)
                            if_data <= mem_rdata;
                        else if (!wr_q)
                            d_rdata <= mem_rdata;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Memory side is driven purely from captured registers so input
    // wiggles during the access cannot leak through.
    always_comb begin
        mem_en    = (state == BUSY);
        mem_wr    = mem_en & wr_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if_valid  = (state == RESP) && (gnt_q == GNT_IF);
        d_valid   = (state == RESP) && (gnt_q == GNT_D);
        stall     = (if_req & ~if_valid) | (d_req & ~d_valid);
    end

endmodule
